// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: runs MULT/MULTU/DIV/DIVU for a fixed busy period, also does MTHI/MTLO.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles, then a one-cycle done pulse; MTHI/MTLO take one edge.
// Backpressure: combinational stall to the hazard unit while a D-stage MDU instruction must wait.
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(NMAX + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_op;      // bit1: divide, bit0: unsigned
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic          r_done;

   logic          w_ld;
   logic          w_fin;
   logic          w_mt_hi;
   logic          w_mt_lo;

   logic          w_is_div;
   logic          w_is_signed;
   logic [63:0]   w_prod;
   logic [31:0]   w_da;
   logic [31:0]   w_db;
   logic [31:0]   w_db_safe;
   logic [31:0]   w_q;
   logic [31:0]   w_r;
   logic [31:0]   w_quo;
   logic [31:0]   w_rem;
   logic          w_div0;

   assign w_is_div    = r_op[1];
   assign w_is_signed = ~r_op[0];

   // Product is built at full 64 bits so the low half of the sign-extended product is exact.
   assign w_prod = w_is_signed ? ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b})
                               : ({32'b0, r_a} * {32'b0, r_b});

   // Signed divide works on magnitudes; 0x80000000 magnitude still fits unsigned 32 bits,
   // so 0x80000000 / -1 naturally yields 0x80000000 with remainder 0.
   assign w_da      = (w_is_signed && r_a[31]) ? (~r_a + 32'd1) : r_a;
   assign w_db      = (w_is_signed && r_b[31]) ? (~r_b + 32'd1) : r_b;
   assign w_div0    = (r_b == 32'd0);
   assign w_db_safe = w_div0 ? 32'd1 : w_db;
   assign w_q       = w_da / w_db_safe;
   assign w_r       = w_da % w_db_safe;
   assign w_quo     = (w_is_signed && (r_a[31] ^ r_b[31])) ? (~w_q + 32'd1) : w_q;
   assign w_rem     = (w_is_signed && r_a[31]) ? (~w_r + 32'd1) : w_r;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and control decode; start is only honoured in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_ld        = 1'b0;
      w_fin       = 1'b0;
      w_mt_hi     = 1'b0;
      w_mt_lo     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (op <= 3'd3) begin
                  w_ld        = 1'b1;
                  w_state_nxt = S_RUN;
               end
               w_mt_hi = (op == 3'd4);
               w_mt_lo = (op == 3'd5);
            end
         end
         S_RUN: begin
            if (r_cnt == CW'(1)) begin
               w_fin       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture, down-counter, HI/LO write-back and done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_op   <= 2'd0;
         r_a    <= 32'd0;
         r_b    <= 32'd0;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_fin;
         if (w_ld) begin
            r_op  <= op[1:0];
            r_a   <= rs_data;
            r_b   <= rt_data;
            r_cnt <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         end else if (w_fin) begin
            r_cnt <= '0;
            if (!w_is_div) begin
               r_hi <= w_prod[63:32];
               r_lo <= w_prod[31:0];
            end else if (!w_div0) begin
               r_hi <= w_rem;
               r_lo <= w_quo;
            end
         end else if (r_state == S_RUN) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
         end else begin
            if (w_mt_hi) r_hi <= rs_data;
            if (w_mt_lo) r_lo <= rs_data;
         end
      end
   end

   assign busy  = (r_state == S_RUN);
   assign stall = d_is_md & (busy | (start & (op <= 3'd3)));
   assign done  = r_done;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL provide parameter MULT_CYCLES, default 5, giving the busy duration of a multiply in cycles.
REQ-002 The block SHALL provide parameter DIV_CYCLES, default 10, giving the busy duration of a divide in cycles.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  E-stage instruction is an MDU operation this cycle.
REQ-006 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; values 6-7 are no-op.
REQ-007 rs_data  input  32  forwarded rs operand (dividend/multiplicand, MTHI/MTLO source).
REQ-008 rt_data  input  32  forwarded rt operand (divisor/multiplier).
REQ-009 d_is_md  input  1  D-stage instruction is any of MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 stall  output  1  combinational stall request to the hazard unit.
REQ-012 done  output  1  one-cycle pulse: new HI/LO visible this cycle.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 The sequencer SHALL have two states, IDLE and RUN, with busy=1 exactly in RUN.
REQ-016 In IDLE, start with op 0-3 at edge T SHALL latch the operation and enter RUN; busy SHALL be 1 for cycles T+1..T+N, where N=MULT_CYCLES for ops 0-1 and N=DIV_CYCLES for ops 2-3.
REQ-017 At the edge ending cycle T+N, the block SHALL write hi/lo, return to IDLE, and assert done for cycle T+N+1 only.
REQ-018 hi and lo SHALL hold their prior values throughout RUN, so MFHI/MFLO never see partial results.
REQ-019 MULT SHALL produce the signed 64-bit product {hi,lo}; MULTU SHALL produce the unsigned 64-bit product.
REQ-020 DIV SHALL set lo to the signed quotient truncated toward zero and hi to the remainder, which takes the sign of the dividend.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-022 DIVU SHALL set lo to the unsigned quotient and hi to the unsigned remainder.
REQ-023 For DIV/DIVU with rt_data=0, the block SHALL run the full DIV_CYCLES busy period, then leave hi/lo unchanged, with done still pulsed.
REQ-024 In IDLE, MTHI/MTLO SHALL write rs_data to hi/lo at the next edge, without entering RUN and without asserting done.
REQ-025 Operands SHALL be captured at the start edge; later changes to rs_data/rt_data SHALL NOT affect the result.
REQ-026 start while in RUN SHALL be ignored, with no state, counter, or hi/lo change.
REQ-027 stall SHALL equal d_is_md AND (busy OR (start AND op<=3)).
REQ-028 stall SHALL be 0 whenever d_is_md=0.
REQ-029 The cycle counter SHALL count from N down to 1 and SHALL NOT wrap or underflow.
REQ-030 N=1 SHALL be legal: busy for one cycle, then done.

Reset
REQ-031 When reset=1 at an edge: state SHALL go to IDLE, busy=0, done=0, hi=0, lo=0, and the counter SHALL clear.
REQ-032 Reset during RUN SHALL abort the operation, with no hi/lo write and no done pulse afterward.
REQ-033 Reset SHALL take priority over start in the same cycle.

Verification
REQ-034 MULT rs=3, rt=0xFFFFFFFE -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for one cycle.
REQ-035 MULTU rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 DIV rs=7, rt=0xFFFFFFFE -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0x00000001.
REQ-037 DIVU rs=5, rt=0 with hi=0x11, lo=0x22 beforehand -> busy for 10 cycles, done pulses, hi=0x11, lo=0x22 unchanged.
REQ-038 MULT issued, then start with op=4 and d_is_md=1 during busy cycle 2 -> stall=1 for all busy cycles, start ignored, final hi = MULT result.
REQ-039 DIV issued, reset asserted in busy cycle 3 -> next cycle busy=0, hi=lo=0, done never asserts.
